// File: rtl/word_ser_pkg.sv
// word_ser_pkg: state encoding and WIDTH limits shared by word_serializer (WORD_SER_PARITY_EN selects the parity beat)
package word_ser_pkg;

    localparam int STATE_W   = 2;
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

    typedef enum logic [STATE_W-1:0] {
        IDLE,
        SHIFT,
        PARITY
    } state_t;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/parity_xor_tree.sv
// parity_xor_tree: XOR reduction of a WIDTH-bit vector built from xor gate instances
module parity_xor_tree #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] vec,
    output logic             parity
);

    logic [WIDTH-1:0] acc;

    assign acc[0] = vec[0];

    for (genvar i = 1; i < WIDTH; i++) begin : g_xor
        xor u_xor (acc[i], acc[i-1], vec[i]);
    end

    assign parity = acc[WIDTH-1];

endmodule

// File: rtl/word_serializer.sv
// word_serializer: WIDTH-bit word to LSB-first bit stream with last-beat marker; WORD_SER_PARITY_EN appends an even-parity beat
module word_serializer
    import word_ser_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_data,
    output logic             ser_last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("word_serializer: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end

    state_t           state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             last_bit;

    assign last_bit = (cnt == LAST);

`ifdef WORD_SER_PARITY_EN
    logic par, par_in;

    parity_xor_tree #(.WIDTH(WIDTH)) u_parity (
        .vec    (in_data),
        .parity (par_in)
    );

    // parity of the word is captured on the same edge that loads the shift register
    always_ff @(posedge clk) begin
        if (rst)
            par <= 1'b0;
        else if (in_valid && in_ready)
            par <= par_in;
    end
`endif

    // state, shift register and beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            shreg <= shreg_nx;
            cnt   <= cnt_nx;
        end
    end

    // next-state and outputs; outputs depend only on registered state and rst
    always_comb begin
        state_nx  = state;
        shreg_nx  = shreg;
        cnt_nx    = cnt;
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        ser_last  = 1'b0;
        if (!rst && state == IDLE) begin
            in_ready = 1'b1;
            if (in_valid) begin
                state_nx = SHIFT;
                shreg_nx = in_data;
                cnt_nx   = '0;
            end
        end
        if (!rst && state == SHIFT) begin
            ser_valid = 1'b1;
            ser_data  = shreg[0];
`ifndef WORD_SER_PARITY_EN
            ser_last  = last_bit;
`endif
            if (ser_ready) begin
                shreg_nx = shreg >> 1;
                cnt_nx   = last_bit ? cnt : cnt + 1'b1;
`ifdef WORD_SER_PARITY_EN
                state_nx = last_bit ? PARITY : SHIFT;
`else
                state_nx = last_bit ? IDLE : SHIFT;
`endif
            end
        end
`ifdef WORD_SER_PARITY_EN
        if (!rst && state == PARITY) begin
            ser_valid = 1'b1;
            ser_last  = 1'b1;
            ser_data  = par;
            if (ser_ready)
                state_nx = IDLE;
        end
`endif
    end

endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: directed table-driven check of word_serializer (expectations follow WORD_SER_PARITY_EN)
module tb_word_serializer;

    localparam int W = 32;
`ifdef WORD_SER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         ser_valid;
    logic         ser_ready = 1'b0;
    logic         ser_data;
    logic         ser_last;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] data;
        logic [3:0]   rpat;
        logic [W-1:0] junk;
    } vec_t;

    vec_t tbl[6];

    word_serializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_data  (ser_data),
        .ser_last  (ser_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_beats(input logic [W-1:0] w, input logic [3:0] rpat);
        logic [W-1:0] got;
        int b;
        int c;
        got = '0;
        b = 0;
        c = 0;
        while (b < NB && c < 20 * NB) begin
            logic exp_bit;
            exp_bit = (b < W) ? w[b] : ^w;
            ser_ready = rpat[c % 4];
            chk($sformatf("beat%0d{valid,data,last,in_ready}", b),
                {ser_valid, ser_data, ser_last, in_ready},
                {1'b1, exp_bit, (b == NB - 1), 1'b0});
            if (ser_ready) begin
                if (b < W)
                    got[b] = ser_data;
                b++;
            end
            c++;
            @(posedge clk);
            @(negedge clk);
        end
        chk("beat_count", b, NB);
        chk("reassembled", got, w);
        chk("idle_bubble{valid,in_ready}", {ser_valid, in_ready}, 2'b01);
    endtask

    task automatic send(input logic [W-1:0] w, input logic [3:0] rpat, input logic [W-1:0] junk);
        in_valid = 1'b1;
        in_data  = w;
        chk("in_ready_idle", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = junk;
        expect_beats(w, rpat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl = '{
            '{32'h0000_0001, 4'b1111, 32'hFFFF_FFFF},
            '{32'hA5A5_A5A5, 4'b0101, 32'h0000_0000},
            '{32'hDEAD_BEEF, 4'b0011, 32'h5A5A_5A5A},
            '{32'h8000_0000, 4'b1110, 32'hFFFF_FFFF},
            '{32'h0000_0000, 4'b1001, 32'hFFFF_FFFF},
            '{32'h0000_0007, 4'b1111, 32'h0000_0000}
        };

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset{in_ready,valid,data,last}", {in_ready, ser_valid, ser_data, ser_last}, 4'b0000);
        rst = 1'b0;
        #1;
        chk("post_reset{in_ready,valid,data,last}", {in_ready, ser_valid, ser_data, ser_last}, 4'b1000);
        @(negedge clk);
        chk("idle_hold{in_ready,valid,data,last}", {in_ready, ser_valid, ser_data, ser_last}, 4'b1000);

        for (int i = 0; i < 6; i++)
            send(tbl[i].data, tbl[i].rpat, tbl[i].junk);

        in_valid = 1'b1;
        in_data  = '1;
        @(posedge clk);
        @(negedge clk);
        in_data = '0;
        expect_beats('1, 4'b1111);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 32'hCAFE_F00D;
        expect_beats('0, 4'b1111);

        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        ser_ready = 1'b1;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("beat10{valid,data}", {ser_valid, ser_data}, {1'b1, 1'b1});
        rst = 1'b1;
        #1;
        chk("rst_mid{in_ready,valid,data,last}", {in_ready, ser_valid, ser_data, ser_last}, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        chk("rst_held{in_ready,valid,data,last}", {in_ready, ser_valid, ser_data, ser_last}, 4'b0000);
        rst = 1'b0;
        #1;
        chk("rst_release{in_ready,valid,data,last}", {in_ready, ser_valid, ser_data, ser_last}, 4'b1000);
        send(32'h0000_0001, 4'b1111, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
